// File: rtl/ring_router_param_if.sv
// Valid/ready packet link used for every router input and output.
// The master drives valid and data; the slave drives ready.
interface ring_router_param_if #(
  parameter int unsigned WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ring_router_param.sv
// Three-port ring router (cw, ccw, pe): per-input FIFOs, one-entry output registers, 2:1 arbiters.
// Define ROUTER_RR_EN for round-robin arbitration; otherwise fixed ring-first / cw-first priority.
module ring_router_param #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned HOP_LSB = 48,
  parameter int unsigned HOP_W   = 8,
  parameter int unsigned DIR_BIT = 62
) (
  input logic                  clk,
  input logic                  reset,
  ring_router_param_if.slave   cw_i,
  ring_router_param_if.slave   ccw_i,
  ring_router_param_if.slave   pe_i,
  ring_router_param_if.master  cw_o,
  ring_router_param_if.master  ccw_o,
  ring_router_param_if.master  pe_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [WIDTH-1:0] pkt_t;

  // Index 0 = cw, 1 = ccw, 2 = pe for both inputs and outputs.
  logic [2:0]      in_valid;
  logic [2:0]      in_ready_q;
  logic [2:0]      push;
  logic [2:0]      pop;
  logic [2:0]      head_vld;
  pkt_t            in_data   [3];
  pkt_t            head      [3];
  pkt_t            mem_q     [3][DEPTH];
  logic [PtrW-1:0] wr_ptr_q  [3];
  logic [PtrW-1:0] rd_ptr_q  [3];
  logic [CntW-1:0] cnt_q     [3];
  logic [CntW-1:0] cnt_d     [3];

  assign in_valid   = {pe_i.valid, ccw_i.valid, cw_i.valid};
  assign in_data[0] = cw_i.data;
  assign in_data[1] = ccw_i.data;
  assign in_data[2] = pe_i.data;
  assign cw_i.ready  = in_ready_q[0];
  assign ccw_i.ready = in_ready_q[1];
  assign pe_i.ready  = in_ready_q[2];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      push[i]     = in_valid[i] & in_ready_q[i];
      head_vld[i] = cnt_q[i] != '0;
      head[i]     = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
  end

  // Ring heads: hop != 0 continues around the ring with hop-1, hop == 0 ejects to pe.
  logic [1:0] hop_nz;
  pkt_t       fwd [2];
  logic       pe_ccw;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hop_nz[i] = head[i][HOP_LSB +: HOP_W] != '0;
      fwd[i]    = head[i];
      fwd[i][HOP_LSB +: HOP_W] = head[i][HOP_LSB +: HOP_W] - HOP_W'(1);
    end
  end

  assign pe_ccw = head[2][DIR_BIT];

  // Source a: cw out <- cw, ccw out <- ccw, pe out <- cw. Source b: pe, pe, ccw.
  logic [2:0] req_a, req_b, gnt_a, gnt_b, prio, ld_en, out_ready, out_vld_q;
  pkt_t       load_data  [3];
  pkt_t       out_data_q [3];

  assign req_a = {head_vld[0] & ~hop_nz[0], head_vld[1] & hop_nz[1], head_vld[0] & hop_nz[0]};
  assign req_b = {head_vld[1] & ~hop_nz[1], head_vld[2] & pe_ccw, head_vld[2] & ~pe_ccw};

  assign out_ready = {pe_o.ready, ccw_o.ready, cw_o.ready};
  assign ld_en     = ~out_vld_q | out_ready;
  assign gnt_a     = ld_en & req_a & (~req_b | ~prio);
  assign gnt_b     = ld_en & req_b & (~req_a | prio);
  assign pop       = {gnt_b[0] | gnt_b[1], gnt_a[1] | gnt_b[2], gnt_a[0] | gnt_a[2]};

  always_comb begin
    load_data[0] = gnt_a[0] ? fwd[0]  : head[2];
    load_data[1] = gnt_a[1] ? fwd[1]  : head[2];
    load_data[2] = gnt_a[2] ? head[0] : head[1];
  end

`ifdef ROUTER_RR_EN
  // prio = 1 favours source b; flips to the loser whenever both requested and a load happened.
  logic [2:0] prio_q;

  assign prio = prio_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_q ^ (ld_en & req_a & req_b);
    end
  end
`else
  assign prio = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      in_ready_q <= '1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        cnt_q[i]      <= cnt_d[i];
        in_ready_q[i] <= cnt_d[i] != CntW'(DEPTH);
      end
    end
  end

  // Storage needs no reset: the counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= '0;
      for (int i = 0; i < 3; i++) out_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld_en[i]) begin
          out_vld_q[i] <= gnt_a[i] | gnt_b[i];
          if (gnt_a[i] | gnt_b[i]) out_data_q[i] <= load_data[i];
        end
      end
    end
  end

  assign cw_o.valid  = out_vld_q[0];
  assign ccw_o.valid = out_vld_q[1];
  assign pe_o.valid  = out_vld_q[2];
  assign cw_o.data   = out_data_q[0];
  assign ccw_o.data  = out_data_q[1];
  assign pe_o.data   = out_data_q[2];

endmodule

// File: tb/tb_ring_router_param.sv
// Directed bench for ring_router_param: vector table for routing plus sequences for
// backpressure, arbitration and reset-while-busy.
module tb_ring_router_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ring_router_param_if #(.WIDTH(64)) cw_in ();
  ring_router_param_if #(.WIDTH(64)) ccw_in ();
  ring_router_param_if #(.WIDTH(64)) pe_in ();
  ring_router_param_if #(.WIDTH(64)) cw_out ();
  ring_router_param_if #(.WIDTH(64)) ccw_out ();
  ring_router_param_if #(.WIDTH(64)) pe_out ();

  ring_router_param #(
    .WIDTH(64), .DEPTH(2), .HOP_LSB(48), .HOP_W(8), .DIR_BIT(62)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cw_i  (cw_in),
    .ccw_i (ccw_in),
    .pe_i  (pe_in),
    .cw_o  (cw_out),
    .ccw_o (ccw_out),
    .pe_o  (pe_out)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic [63:0] din;
    logic [2:0]  ovld;
    int          oport;
    logic [63:0] dout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] vld_vec();
    return {pe_out.valid, ccw_out.valid, cw_out.valid};
  endfunction

  function automatic logic [2:0] rdy_vec();
    return {pe_in.ready, ccw_in.ready, cw_in.ready};
  endfunction

  function automatic logic [63:0] out_data(input int p);
    case (p)
      0:       return cw_out.data;
      1:       return ccw_out.data;
      default: return pe_out.data;
    endcase
  endfunction

  task automatic drive_in(input int p, input logic v, input logic [63:0] d);
    case (p)
      0: begin cw_in.valid  = v; cw_in.data  = d; end
      1: begin ccw_in.valid = v; ccw_in.data = d; end
      default: begin pe_in.valid = v; pe_in.data = d; end
    endcase
  endtask

  task automatic set_out_ready(input logic [2:0] r);
    cw_out.ready  = r[0];
    ccw_out.ready = r[1];
    pe_out.ready  = r[2];
  endtask

  // Holds valid until the packet is taken; a stuck ready counts as a failure.
  task automatic send(input int p, input logic [63:0] d, input string name);
    logic r;
    drive_in(p, 1'b1, d);
    for (int c = 0; c < 20; c++) begin
      r = rdy_vec()[p];
      tick();
      if (r) begin
        drive_in(p, 1'b0, 64'h0);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=accept", name);
    drive_in(p, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    tick();
    tick();
    #3 reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] got_q [$];
  logic [63:0] exp_arb [12];
  logic [63:0] bp_exp [3];
  logic [2:0]  seen;

  initial begin
    vecs[0] = '{0, 64'h0103_0000_dead_beef, 3'b001, 0, 64'h0102_0000_dead_beef};
    vecs[1] = '{1, 64'h2200_1111_2222_3333, 3'b100, 2, 64'h2200_1111_2222_3333};
    vecs[2] = '{2, 64'h4005_aaaa_bbbb_cccc, 3'b010, 1, 64'h4005_aaaa_bbbb_cccc};
    vecs[3] = '{2, 64'h8007_1234_5678_9abc, 3'b001, 0, 64'h8007_1234_5678_9abc};
    vecs[4] = '{1, 64'h0001_0000_0000_0001, 3'b010, 1, 64'h0000_0000_0000_0001};
    vecs[5] = '{0, 64'hff00_ffff_ffff_ffff, 3'b100, 2, 64'hff00_ffff_ffff_ffff};
    vecs[6] = '{1, 64'h00ff_0000_0000_0000, 3'b010, 1, 64'h00fe_0000_0000_0000};
    vecs[7] = '{0, 64'h3c80_5a5a_5a5a_5a5a, 3'b001, 0, 64'h3c7f_5a5a_5a5a_5a5a};

    reset = 1'b1;
    for (int p = 0; p < 3; p++) drive_in(p, 1'b0, 64'h0);
    set_out_ready(3'b111);
    #12 reset = 1'b0;
    tick();

    check("reset_ready", {61'h0, rdy_vec()}, 64'h7);
    check("reset_valid", {61'h0, vld_vec()}, 64'h0);
    check("reset_data", cw_out.data | ccw_out.data | pe_out.data, 64'h0);

    // Single packets: nothing one cycle after accept, output exactly two cycles after, then gone.
    for (int v = 0; v < 8; v++) begin
      drive_in(vecs[v].port, 1'b1, vecs[v].din);
      tick();
      drive_in(vecs[v].port, 1'b0, 64'h0);
      check($sformatf("vec%0d_early", v), {61'h0, vld_vec()}, 64'h0);
      tick();
      check($sformatf("vec%0d_valid", v), {61'h0, vld_vec()}, {61'h0, vecs[v].ovld});
      check($sformatf("vec%0d_data", v), out_data(vecs[v].oport), vecs[v].dout);
      tick();
      check($sformatf("vec%0d_drained", v), {61'h0, vld_vec()}, 64'h0);
    end

    // Backpressure: three packets fill output register plus both FIFO entries.
    set_out_ready(3'b110);
    send(0, 64'h0001_0000_0000_00a0, "bp_send0");
    send(0, 64'h0001_0000_0000_00a1, "bp_send1");
    send(0, 64'h0001_0000_0000_00a2, "bp_send2");
    check("bp_ready_low", {63'h0, cw_in.ready}, 64'h0);
    check("bp_valid", {63'h0, cw_out.valid}, 64'h1);
    check("bp_head", cw_out.data, 64'h0000_0000_0000_00a0);
    tick();
    tick();
    tick();
    check("bp_hold_data", cw_out.data, 64'h0000_0000_0000_00a0);
    check("bp_hold_ready", {63'h0, cw_in.ready}, 64'h0);
    bp_exp[0] = 64'h0000_0000_0000_00a0;
    bp_exp[1] = 64'h0000_0000_0000_00a1;
    bp_exp[2] = 64'h0000_0000_0000_00a2;
    cw_out.ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 12; c++) begin
      if (cw_out.valid) got_q.push_back(cw_out.data);
      tick();
    end
    check("bp_count", 64'(got_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      check($sformatf("bp_order%0d", i), got_q[i], bp_exp[i]);
    end
    check("bp_ready_back", {63'h0, cw_in.ready}, 64'h1);

    // Arbitration on cw out: cw stream (hop 1) against pe stream (dir cw).
    do_reset();
    set_out_ready(3'b111);
    for (int k = 0; k < 6; k++) begin
`ifdef ROUTER_RR_EN
      exp_arb[2*k]   = 64'(k);
      exp_arb[2*k+1] = 64'h100 | 64'(k);
`else
      exp_arb[k]     = 64'(k);
      exp_arb[6+k]   = 64'h100 | 64'(k);
`endif
    end
    got_q.delete();
    begin
      int  cs, ps;
      logic acc_c, acc_p;
      cs = 0;
      ps = 0;
      for (int c = 0; c < 60; c++) begin
        drive_in(0, cs < 6, 64'h0001_0000_0000_0000 | 64'(cs));
        drive_in(2, ps < 6, 64'h0000_0000_0000_0100 | 64'(ps));
        acc_c = cw_in.valid & cw_in.ready;
        acc_p = pe_in.valid & pe_in.ready;
        if (cw_out.valid) got_q.push_back(cw_out.data);
        tick();
        if (acc_c) cs++;
        if (acc_p) ps++;
      end
      drive_in(0, 1'b0, 64'h0);
      drive_in(2, 1'b0, 64'h0);
    end
    check("arb_count", 64'(got_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      check($sformatf("arb_order%0d", i), got_q[i], exp_arb[i]);
    end

    // Reset with packets buffered everywhere.
    set_out_ready(3'b000);
    drive_in(0, 1'b1, 64'h0001_0000_0000_0c01);
    drive_in(1, 1'b1, 64'h0001_0000_0000_0c02);
    drive_in(2, 1'b1, 64'h0000_0000_0000_0c03);
    for (int c = 0; c < 5; c++) tick();
    check("busy_valid", {61'h0, vld_vec()}, 64'h3);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", {61'h0, vld_vec()}, 64'h0);
    check("rst_async_ready", {61'h0, rdy_vec()}, 64'h7);
    check("rst_async_data", cw_out.data | ccw_out.data | pe_out.data, 64'h0);
    for (int p = 0; p < 3; p++) drive_in(p, 1'b0, 64'h0);
    tick();
    #3 reset = 1'b0;
    set_out_ready(3'b111);
    seen = 3'b000;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen |= vld_vec();
    end
    check("no_stale", {61'h0, seen}, 64'h0);
    check("post_rst_ready", {61'h0, rdy_vec()}, 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_router_param.md
# ring_router_param

Parametrised three-port ring router: clockwise ring (cw), counter-clockwise ring (ccw) and local processing element (pe). Each input owns a DEPTH-entry FIFO, each output owns a one-entry output register with valid/ready handshake, and each output arbitrates between its two possible sources. Forwarded ring packets have their hop count decremented in flight. Drop-in replacement for the single-buffer ring router in each ring node, with configurable width, buffering and header field positions.

## Interface
- WIDTH, 64, packet width in bits
- DEPTH, 2, input FIFO entries per port; power of two, >= 2
- HOP_LSB, 48, LSB of hop-count field
- HOP_W, 8, hop-count field width
- DIR_BIT, 62, pe-packet direction bit: 0 = cw, 1 = ccw
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cwsi / ccwsi / pesi  in  1  upstream send (valid) per input
- cwri / ccwri / peri  out  1  input ready: FIFO not full
- cwdi / ccwdi / pedi  in  WIDTH  input packet
- cwso / ccwso / peso  out  1  output register valid
- cwro / ccwro / pero  in  1  downstream ready
- cwdo / ccwdo / pedo  out  WIDTH  output packet

## Operation
- Input accept: xsi && xri at an edge pushes xdi. xri = !full, registered from FIFO count; never depends on xsi.
- FIFO: circular, log2(DEPTH)-bit pointers wrapping modulo DEPTH, (log2(DEPTH)+1)-bit count. Push and pop in one cycle leave count unchanged; push-when-full is impossible because ri = 0.
- Route from FIFO head:
  - cw/ccw head, hop != 0 -> same-direction ring output, hop field replaced by hop-1 (HOP_W-bit, no wrap since hop != 0). Other bits unchanged.
  - cw/ccw head, hop == 0 -> pe output, unmodified.
  - pe head: DIR_BIT = 0 -> cw output, 1 -> ccw output, unmodified.
- Sources per output: cw out <- {cw in, pe in}; ccw out <- {ccw in, pe in}; pe out <- {cw in, ccw in}.
- Output register loads when empty, or being drained this cycle (xso && xro). One grant per output per cycle. Granted FIFO pops in the same edge.
- Output drain: xso && xro at an edge. xdo holds stable while xso = 1 and xro = 0.
- Arbitration: one priority bit per output. Reset value favours the ring input for the cw/ccw outputs and cw for the pe output. After a grant with both sources requesting, priority moves to the loser. A lone requester always wins.
- Each input has exactly one destination, so at most one pop per FIFO per cycle.

## Timing
- Reset (async assert, sync release): all FIFOs empty, pointers 0. xri = 1, xso = 0, xdo = 0, priority bits at reset value. Reset mid-transfer discards all buffered packets.
- Latency: accept at edge N, head valid in cycle N+1, output register loaded at edge N+1, xso = 1 in cycle N+2. Minimum 2 cycles in-to-out.
- Throughput: 1 packet/cycle per output with xro held high, including simultaneous drain and load.
- xri deasserts in the cycle after the FIFO reaches DEPTH entries. It reasserts in the cycle after a pop from full.
- Backpressure: xro = 0 holds the output register. Its sources stall in their FIFOs; nothing is dropped or duplicated.

## Configuration
- ROUTER_RR_EN defined: round-robin arbitration as above.
- ROUTER_RR_EN undefined: fixed priority. Ring input beats pe on cw/ccw outputs; cw beats ccw on pe output. Priority bits are not instantiated. A starving source is legal in this mode.

## Test plan
- Reset then single cwdi with hop = 3, cwro = 1 -> cwso = 1 exactly 2 cycles after accept, cwdo hop field = 2, other bits identical.
- ccwdi with hop = 0 -> appears on pedo unchanged; ccwso stays 0.
- pedi with DIR_BIT = 1, then DIR_BIT = 0 -> first packet on ccwdo, second on cwdo, hop fields untouched.
- Hold cwro = 0, send DEPTH+1 packets on cw -> cwri = 0 after the FIFO fills plus the output register is loaded. Release cwro -> all packets delivered in order, none lost.
- With ROUTER_RR_EN, cw hop = 1 and pe DIR_BIT = 0 streaming continuously -> cwdo alternates cw, pe, cw, pe. Without the macro -> only cw packets until the cw stream stops.
- Assert reset with packets in all FIFOs and outputs -> same cycle xso = 0, xri = 1. After release, no stale packet emerges.
